// File: rtl/qfix_pkg.sv
// Shared fixed-point definitions for the sign-magnitude neuron-lane datapath.
package qfix_pkg;

    localparam int unsigned QF_N     = 32;
    localparam int unsigned QF_Q     = 15;
    localparam int unsigned QF_CNTW  = 16;
    localparam int unsigned SIGN_BIT = QF_N - 1;
    localparam logic [QF_N-2:0] MAG_MAX = {(QF_N-1){1'b1}};

    // Accumulator group state: no open group / group open
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_e;

endpackage

// File: rtl/sm_add_sat.sv
// Combinational sign-magnitude adder with magnitude saturation; never emits -0.
module sm_add_sat
    import qfix_pkg::*;
#(
    parameter int unsigned N = QF_N
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic [N-1:0] o_y_c,
    output logic         o_ovf_c
);

    localparam int unsigned MW = N - 1;

    logic          w_sa;
    logic          w_sb;
    logic [MW-1:0] w_ma;
    logic [MW-1:0] w_mb;
    logic [N-1:0]  w_sum;
    logic          w_a_ge_b;
    logic [MW-1:0] w_diff;
    logic [MW-1:0] w_mag;
    logic          w_sign;

    assign w_sa     = i_a[N-1];
    assign w_sb     = i_b[N-1];
    assign w_ma     = i_a[MW-1:0];
    assign w_mb     = i_b[MW-1:0];
    assign w_sum    = {1'b0, w_ma} + {1'b0, w_mb};
    assign w_a_ge_b = (w_ma >= w_mb);
    assign w_diff   = w_a_ge_b ? (w_ma - w_mb) : (w_mb - w_ma);

    // Select same-sign sum (with clamp) or differing-sign difference, then squash -0
    always_comb begin
        w_mag   = '0;
        w_sign  = 1'b0;
        o_ovf_c = 1'b0;
        if (w_sa == w_sb) begin
            w_sign = w_sa;
            if (w_sum[N-1]) begin
                w_mag   = {MW{1'b1}};
                o_ovf_c = 1'b1;
            end else begin
                w_mag = w_sum[MW-1:0];
            end
        end else begin
            w_mag  = w_diff;
            w_sign = w_a_ge_b ? w_sa : w_sb;
        end
        if (w_mag == '0) begin
            w_sign = 1'b0;
        end
    end

    assign o_y_c = {w_sign, w_mag};

endmodule

// File: rtl/qacc_stream.sv
// Streaming sign-magnitude group accumulator: sums in_last-delimited groups with
// saturation and emits one registered result (sum, sticky sat, beat count) per group.
module qacc_stream
    import qfix_pkg::*;
#(
    parameter int unsigned N    = QF_N,
    parameter int unsigned Q    = QF_Q,
    parameter int unsigned CNTW = QF_CNTW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    in_data,
    input  logic            in_last,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    out_data,
    output logic            out_sat,
    output logic [CNTW-1:0] out_cnt
);

    // Fraction width is only carried by the data; guard against a nonsense setting
    if (Q > N - 1) begin : g_q_check
        $error("qacc_stream: Q must not exceed the magnitude width");
    end

    state_e          r_state;
    state_e          w_state_nxt;
    logic [N-1:0]    r_acc;
    logic [N-1:0]    w_acc_nxt;
    logic            r_sat;
    logic            w_sat_nxt;
    logic [CNTW-1:0] r_cnt;
    logic [CNTW-1:0] w_cnt_nxt;

    logic            r_out_valid;
    logic [N-1:0]    r_out_data;
    logic            r_out_sat;
    logic [CNTW-1:0] r_out_cnt;

    logic            w_fire;
    logic            w_load;
    logic [N-1:0]    w_res_data;
    logic            w_res_sat;
    logic [CNTW-1:0] w_res_cnt;
    logic [N-1:0]    w_in_norm;
    logic [N-1:0]    w_add;
    logic            w_ovf;
    logic [CNTW-1:0] w_cnt_inc;

    // Ready only depends on the output slot: free, or draining this cycle
    assign in_ready  = !r_out_valid || out_ready;
    assign w_fire    = in_valid && in_ready;
    assign w_in_norm = (in_data[N-2:0] == '0) ? '0 : in_data;
    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CNTW'(1);

    sm_add_sat #(
        .N (N)
    ) u_add (
        .i_a     (r_acc),
        .i_b     (in_data),
        .o_y_c   (w_add),
        .o_ovf_c (w_ovf)
    );

    // Next-state and datapath decisions for the open/closed group
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_sat_nxt   = r_sat;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        w_res_data  = w_add;
        w_res_sat   = r_sat | w_ovf;
        w_res_cnt   = w_cnt_inc;
        case (r_state)
            ST_IDLE: begin
                if (w_fire) begin
                    if (in_last) begin
                        w_load     = 1'b1;
                        w_res_data = w_in_norm;
                        w_res_sat  = 1'b0;
                        w_res_cnt  = CNTW'(1);
                    end else begin
                        w_state_nxt = ST_ACCUM;
                        w_acc_nxt   = w_in_norm;
                        w_sat_nxt   = 1'b0;
                        w_cnt_nxt   = CNTW'(1);
                    end
                end
            end
            ST_ACCUM: begin
                if (w_fire) begin
                    if (in_last) begin
                        w_load      = 1'b1;
                        w_state_nxt = ST_IDLE;
                        w_acc_nxt   = '0;
                        w_sat_nxt   = 1'b0;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_acc_nxt = w_add;
                        w_sat_nxt = r_sat | w_ovf;
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Group state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Running accumulator, sticky saturation and beat count of the open group
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_sat <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_acc <= w_acc_nxt;
            r_sat <= w_sat_nxt;
            r_cnt <= w_cnt_nxt;
        end
    end

    // Output slot: load on a last beat, clear when drained, hold while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
            r_out_cnt   <= '0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_res_data;
            r_out_sat   <= w_res_sat;
            r_out_cnt   <= w_res_cnt;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sat   = r_out_sat;
    assign out_cnt   = r_out_cnt;

endmodule

// File: tb/tb_qacc_stream.sv
// Self-checking bench for qacc_stream: directed cases plus randomized grouped traffic
// scored against a signed-integer reference of the group sum.
module tb_qacc_stream;

    localparam longint MAGMAX = 64'sd2147483647;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_sat;
    logic [15:0] out_cnt;

    typedef struct {
        logic [31:0] d;
        logic        s;
        logic [15:0] c;
    } res_t;

    res_t        q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_push   = 0;
    int          n_out    = 0;
    bit          m_open   = 1'b0;
    bit          m_sat    = 1'b0;
    longint      m_acc    = 0;
    int          m_cnt    = 0;
    bit          pend     = 1'b0;
    bit          rand_rdy = 1'b0;
    logic [31:0] cap_d    = '0;
    logic        cap_s    = 1'b0;
    logic [15:0] cap_c    = '0;

    qacc_stream #(.N(32), .Q(15), .CNTW(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .out_cnt   (out_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint sm2v(input logic [31:0] x);
        longint m;
        m = longint'(x[30:0]);
        return x[31] ? -m : m;
    endfunction

    function automatic logic [31:0] v2sm(input longint v);
        if (v < 0) return {1'b1, 31'(-v)};
        return {1'b0, 31'(v)};
    endfunction

    // Reference: signed integer sum clamped to +/-MAGMAX, sticky clamp flag
    task automatic model_beat(input logic [31:0] d, input logic last);
        longint v;
        longint s;
        res_t   r;
        v = sm2v(d);
        if (!m_open) begin
            m_acc = v;
            m_sat = 1'b0;
            m_cnt = 1;
        end else begin
            s = m_acc + v;
            if (s > MAGMAX) begin
                s = MAGMAX;
                m_sat = 1'b1;
            end else if (s < -MAGMAX) begin
                s = -MAGMAX;
                m_sat = 1'b1;
            end
            m_acc = s;
            m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
        end
        if (last) begin
            r.d = v2sm(m_acc);
            r.s = m_sat;
            r.c = 16'(m_cnt);
            q.push_back(r);
            n_push++;
            m_open = 1'b0;
            pend   = 1'b1;
        end else begin
            m_open = 1'b1;
        end
    endtask

    // Mid-cycle observation of both handshakes against the reference queue
    task automatic mon_step();
        if (!rst_n) begin
            m_open = 1'b0;
            pend   = 1'b0;
            q.delete();
            return;
        end
        if (pend) begin
            chk("latency_valid", 64'(out_valid), 64'(1));
            pend = 1'b0;
        end
        if (out_valid) begin
            if (q.size() == 0) begin
                chk("spurious_out", 64'(out_valid), 64'(0));
            end else begin
                chk("out_data", 64'(out_data), 64'(q[0].d));
                chk("out_sat",  64'(out_sat),  64'(q[0].s));
                chk("out_cnt",  64'(out_cnt),  64'(q[0].c));
                if (out_ready) begin
                    cap_d = out_data;
                    cap_s = out_sat;
                    cap_c = out_cnt;
                    void'(q.pop_front());
                    n_out++;
                end
            end
        end
        if (in_valid && in_ready) begin
            model_beat(in_data, in_last);
        end
    endtask

    task automatic rnd_rdy();
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_beat(input logic [31:0] d, input logic l);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
            rnd_rdy();
        end
        chk("beat_accepted", 64'(ok), 64'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        rnd_rdy();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            rnd_rdy();
        end
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        rand_rdy  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (q.size() == 0 && !out_valid) begin
                done = 1'b1;
                break;
            end
        end
        chk("drain_done", 64'(done), 64'(1));
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] rnd_word();
        int          sel;
        logic        sg;
        logic [30:0] m;
        sel = $urandom_range(0, 9);
        sg  = 1'($urandom_range(0, 1));
        case (sel)
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2, 3: begin
                m = 31'h7FFF_0000 | 31'($urandom_range(0, 32'h0000_FFFF));
                return {sg, m};
            end
            default: begin
                m = 31'($urandom_range(0, 32'h0010_0000));
                return {sg, m};
            end
        endcase
    endfunction

    initial begin
        int n_before;
        int len;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        fork
            forever begin
                @(negedge clk);
                mon_step();
            end
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data",  64'(out_data),  64'(0));
        chk("rst_out_sat",   64'(out_sat),   64'(0));
        chk("rst_out_cnt",   64'(out_cnt),   64'(0));
        chk("rst_in_ready",  64'(in_ready),  64'(1));
        @(posedge clk); #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        idle(2);

        // 1.0 + 1.0 - 0.5 = 1.5
        send_beat(32'h0000_8000, 1'b0);
        send_beat(32'h0000_8000, 1'b0);
        send_beat(32'h8000_4000, 1'b1);
        wait_idle();
        chk("t1_data", 64'(cap_d), 64'(32'h0000_C000));
        chk("t1_sat",  64'(cap_s), 64'(0));
        chk("t1_cnt",  64'(cap_c), 64'(3));

        // Positive saturation
        send_beat(32'h7FFF_FFFF, 1'b0);
        send_beat(32'h0000_0001, 1'b1);
        wait_idle();
        chk("t2_data", 64'(cap_d), 64'(32'h7FFF_FFFF));
        chk("t2_sat",  64'(cap_s), 64'(1));
        chk("t2_cnt",  64'(cap_c), 64'(2));

        // +1 + -1 gives +0; lone -0 gives +0
        send_beat(32'h0000_8000, 1'b0);
        send_beat(32'h8000_8000, 1'b1);
        wait_idle();
        chk("t3_zero", 64'(cap_d), 64'(0));
        send_beat(32'h8000_0000, 1'b1);
        wait_idle();
        chk("t3_negzero", 64'(cap_d), 64'(0));
        chk("t3_cnt",     64'(cap_c), 64'(1));

        // Backpressure, then drain and reload in the same cycle
        out_ready = 1'b0;
        send_beat(32'h0000_8000, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_hold_ready", 64'(in_ready),  64'(0));
            chk("t4_hold_valid", 64'(out_valid), 64'(1));
            chk("t4_hold_data",  64'(out_data),  64'(32'h0000_8000));
        end
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = 32'h0000_0003;
        in_last  = 1'b1;
        @(negedge clk);
        chk("t4_blocked", 64'(in_ready), 64'(0));
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("t4_open", 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        chk("t4_b2b_valid", 64'(out_valid), 64'(1));
        chk("t4_b2b_data",  64'(out_data),  64'(32'h0000_0003));
        wait_idle();
        chk("t4_cap", 64'(cap_d), 64'(32'h0000_0003));

        // Reset mid-group discards the partial sum
        n_before = n_out;
        send_beat(32'h0000_0100, 1'b0);
        send_beat(32'h0000_0200, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_rst_valid", 64'(out_valid), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        send_beat(32'h0000_0002, 1'b1);
        wait_idle();
        chk("t5_data",   64'(cap_d), 64'(32'h0000_0002));
        chk("t5_cnt",    64'(cap_c), 64'(1));
        chk("t5_n_out",  64'(n_out), 64'(n_before + 1));

        // Random grouped traffic with random backpressure
        n_before = n_push;
        rand_rdy = 1'b1;
        for (int g = 0; g < 150; g++) begin
            len = $urandom_range(1, 5);
            for (int b = 0; b < len; b++) begin
                send_beat(rnd_word(), (b == len - 1));
            end
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        wait_idle();
        chk("t6_groups", 64'(n_push - n_before), 64'(150));
        chk("t6_all_out", 64'(n_out), 64'(n_push));
        chk("t6_queue_empty", 64'(q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
